// File: rtl/bmem_responder_if.sv
// rtl/bmem_responder_if.sv - bmem burst bus between the L2-side initiator and the memory responder
interface bmem_responder_if;
    logic [31:0] bmem_addr;
    logic        bmem_read;
    logic        bmem_write;
    logic [63:0] bmem_wdata;
    logic        bmem_ready;
    logic [31:0] bmem_raddr;
    logic [63:0] bmem_rdata;
    logic        bmem_rvalid;

    modport master (
        output bmem_addr, bmem_read, bmem_write, bmem_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );

    modport slave (
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );
endinterface

// File: rtl/bmem_responder.sv
// rtl/bmem_responder.sv - bmem burst memory responder: write bursts in, fixed-latency read bursts out
// Optional BMEM_RESP_RAND_LAT_EN adds 0..7 cycles of LFSR-driven extra read latency.
module bmem_responder #(
    parameter int BURST_LEN     = 4,
    parameter int READ_LATENCY  = 8,
    parameter int QUEUE_DEPTH   = 4,
    parameter int MEM_ADDR_BITS = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    bmem_responder_if.slave bmem
);
    localparam int OFF_BITS  = $clog2(BURST_LEN * 8);
    localparam int BEAT_BITS = $clog2(BURST_LEN);
    localparam int LINE_BITS = MEM_ADDR_BITS - BEAT_BITS;
    localparam int TAG_BITS  = 32 - OFF_BITS;
    localparam int CNT_W     = $clog2(READ_LATENCY + QUEUE_DEPTH * BURST_LEN) + 2;
    localparam int PTR_W     = $clog2(QUEUE_DEPTH);
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BURST_LEN - 1);
    localparam logic [PTR_W:0]       Q_FULL    = (PTR_W+1)'(QUEUE_DEPTH);

    typedef enum logic { W_IDLE, W_BURST } w_state_t;
    typedef enum logic { R_IDLE, R_BEAT }  r_state_t;

    w_state_t                 r_wstate, w_wstate_nxt;
    r_state_t                 r_rstate, w_rstate_nxt;
    logic [BEAT_BITS-1:0]     r_wbeat, w_wbeat_nxt, r_rbeat, w_rbeat_nxt;
    logic [63:0]              r_mem [0:(1<<MEM_ADDR_BITS)-1];
    logic [TAG_BITS-1:0]      r_q_tag [QUEUE_DEPTH];
    logic [CNT_W-1:0]         r_q_due [QUEUE_DEPTH];
    logic [PTR_W-1:0]         r_wr_ptr, r_rd_ptr, w_nxt_ptr, w_out_ptr;
    logic [PTR_W:0]           r_count;
    logic [CNT_W-1:0]         r_cnt, w_extra, w_head_diff, w_nxt_diff;
    logic                     r_live, r_rvalid;
    logic [31:0]              r_raddr;
    logic [63:0]              r_rdata;
    logic                     w_ready, w_wr_en, w_push, w_pop, w_go;
    logic                     w_head_due, w_nxt_due, w_hazard, w_unused_addr;
    logic [MEM_ADDR_BITS-1:0] w_wr_idx, w_rd_idx;
    logic [LINE_BITS-1:0]     w_req_line;

    assign w_req_line    = bmem.bmem_addr[LINE_BITS+OFF_BITS-1:OFF_BITS];
    assign w_unused_addr = ^bmem.bmem_addr[OFF_BITS-1:0];
    assign w_ready       = r_live && ((r_wstate == W_BURST) || (r_count != Q_FULL));
    assign w_wr_en       = bmem.bmem_write && w_ready;
    assign w_push        = (r_wstate == W_IDLE) && bmem.bmem_read && !bmem.bmem_write && w_ready;
    assign w_wr_idx      = {w_req_line, (r_wstate == W_IDLE) ? {BEAT_BITS{1'b0}} : r_wbeat};

    // Due tests look one cycle ahead because the beat outputs are registered.
    assign w_nxt_ptr   = r_rd_ptr + PTR_W'(1);
    assign w_head_diff = r_cnt + CNT_W'(1) - r_q_due[r_rd_ptr];
    assign w_nxt_diff  = r_cnt + CNT_W'(1) - r_q_due[w_nxt_ptr];
    assign w_head_due  = (r_count != '0) && !w_head_diff[CNT_W-1];
    assign w_nxt_due   = (r_count > (PTR_W+1)'(1)) && !w_nxt_diff[CNT_W-1];
    assign w_rd_idx    = {r_q_tag[w_out_ptr][LINE_BITS-1:0], w_rbeat_nxt};

`ifdef BMEM_RESP_RAND_LAT_EN
    logic [15:0] r_lfsr;
    assign w_extra = CNT_W'(r_lfsr[2:0]);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_lfsr <= 16'hACE1;
        else if (w_push)
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end
`else
    assign w_extra = '0;
`endif

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_wbeat_nxt  = r_wbeat;
        case (r_wstate)
            W_IDLE: if (w_wr_en) begin
                w_wstate_nxt = W_BURST;
                w_wbeat_nxt  = BEAT_BITS'(1);
            end
            W_BURST: if (!bmem.bmem_write || (r_wbeat == LAST_BEAT)) begin
                w_wstate_nxt = W_IDLE;
                w_wbeat_nxt  = '0;
            end else begin
                w_wbeat_nxt  = r_wbeat + BEAT_BITS'(1);
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // r_rbeat is the beat on the output this cycle; the *_nxt values select next cycle's beat.
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_rbeat_nxt  = r_rbeat;
        w_pop        = 1'b0;
        w_go         = 1'b0;
        w_out_ptr    = r_rd_ptr;
        case (r_rstate)
            R_IDLE: if (w_head_due) begin
                w_rstate_nxt = R_BEAT;
                w_rbeat_nxt  = '0;
                w_go         = 1'b1;
            end
            R_BEAT: if (r_rbeat != LAST_BEAT) begin
                w_rbeat_nxt = r_rbeat + BEAT_BITS'(1);
                w_go        = 1'b1;
            end else begin
                w_pop       = 1'b1;
                w_rbeat_nxt = '0;
                if (w_nxt_due) begin
                    w_go      = 1'b1;
                    w_out_ptr = w_nxt_ptr;
                end else begin
                    w_rstate_nxt = R_IDLE;
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
            r_wbeat  <= '0;
            r_rbeat  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_cnt    <= '0;
            r_live   <= 1'b0;
            r_rvalid <= 1'b0;
            r_raddr  <= '0;
            r_rdata  <= '0;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
            r_wbeat  <= w_wbeat_nxt;
            r_rbeat  <= w_rbeat_nxt;
            r_cnt    <= r_cnt + CNT_W'(1);
            r_live   <= 1'b1;
            r_count  <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= w_nxt_ptr;
            r_rvalid <= w_go;
            if (w_go) begin
                r_raddr <= {r_q_tag[w_out_ptr], {OFF_BITS{1'b0}}};
                r_rdata <= r_mem[w_rd_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[w_wr_idx] <= bmem.bmem_wdata;
        if (w_push) begin
            r_q_tag[r_wr_ptr] <= bmem.bmem_addr[31:OFF_BITS];
            r_q_due[r_wr_ptr] <= r_cnt + CNT_W'(READ_LATENCY) + w_extra;
        end
    end

    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (({1'b0, PTR_W'(PTR_W'(i) - r_rd_ptr)} < r_count) &&
                (r_q_tag[i][LINE_BITS-1:0] == w_req_line))
                w_hazard = 1'b1;
        end
    end

    // Reads sample the array at beat time, so a write into a pending line would corrupt the return.
    a_no_write_pending_line: assert property (@(posedge clk) disable iff (!rst_n) !(w_wr_en && w_hazard));

    assign bmem.bmem_ready  = w_ready;
    assign bmem.bmem_rvalid = r_rvalid;
    assign bmem.bmem_raddr  = r_raddr;
    assign bmem.bmem_rdata  = r_rdata;
endmodule

// File: tb/tb_bmem_responder.sv
// tb/tb_bmem_responder.sv - randomized scoreboard bench for bmem_responder
module tb_bmem_responder;
`ifdef BMEM_RESP_RAND_LAT_EN
    localparam int LAT_SPAN = 7;
    localparam bit SEQ      = 1'b1;
`else
    localparam int LAT_SPAN = 0;
    localparam bit SEQ      = 1'b0;
`endif
    localparam int READ_LAT = 8;
    localparam int QDEPTH   = 4;

    typedef struct {
        int          k;
        int          lo;
        int          hi;
        logic [31:0] raddr;
        logic [63:0] data;
    } beat_t;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    int          cyc      = 0;
    int          n_checks = 0;
    int          n_pass   = 0;
    beat_t       sb[$];
    beat_t       mon_e;
    int          mon_t0   = 0;
    logic [63:0] model[int];
    int          pend_end[$];
    int          last_end = -1;
    logic [63:0] wd[4];

    bmem_responder_if bif();

    bmem_responder #(
        .BURST_LEN(4), .READ_LATENCY(READ_LAT), .QUEUE_DEPTH(QDEPTH), .MEM_ADDR_BITS(12)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bmem (bif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int widx(input logic [31:0] a, input int k);
        return int'((a >> 5) & 32'h3FF) * 4 + k;
    endfunction

    // First cycle at or after p with fewer than QDEPTH reads still returning.
    function automatic int predict_accept(input int p);
        int x;
        int busy;
        x = p;
        for (int guard = 0; guard < 1000; guard++) begin
            busy = 0;
            foreach (pend_end[i]) if (pend_end[i] >= x) busy++;
            if (busy < QDEPTH) return x;
            x++;
        end
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d..%0d", name, act, lo, hi);
    endtask

    always @(negedge clk) begin
        if (rst_n && bif.bmem_rvalid) begin
            if (sb.size() == 0) begin
                check("unexpected_rvalid", 64'(bif.bmem_rvalid), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.k == 0) begin
                    check_rng("first_beat_cycle", cyc, mon_e.lo, mon_e.hi);
                    mon_t0 = cyc;
                end else begin
                    check_rng("beat_cycle", cyc, mon_t0 + mon_e.k, mon_t0 + mon_e.k);
                end
                check("raddr", 64'(bif.bmem_raddr), 64'(mon_e.raddr));
                check("rdata", bif.bmem_rdata, mon_e.data);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", 64'(sb.size()), 64'd0);
        sb.delete();
        pend_end.delete();
        last_end = cyc - 1;
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [31:0] a, input int nbeats, input logic with_rd);
        for (int k = 0; k < nbeats; k++) begin
            bif.bmem_addr  = a;
            bif.bmem_write = 1'b1;
            bif.bmem_wdata = wd[k];
            bif.bmem_read  = with_rd;
            model[widx(a, k)] = wd[k];
            if (k == 0) begin
                @(negedge clk);
                check("wr_ready", 64'(bif.bmem_ready), 64'd1);
            end
            @(posedge clk); #1;
        end
        bif.bmem_write = 1'b0;
        bif.bmem_read  = 1'b0;
        if (nbeats < 4) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_read(input logic [31:0] a);
        int exp_acc;
        int acc;
        int first;
        int n;
        if (SEQ) wait_idle();
        exp_acc = predict_accept(cyc);
        bif.bmem_addr  = a;
        bif.bmem_read  = 1'b1;
        bif.bmem_write = 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            if (bif.bmem_ready) break;
            n++;
            if (n > 200) break;
            @(posedge clk); #1;
        end
        acc = cyc;
        @(posedge clk); #1;
        bif.bmem_read = 1'b0;
        check("rd_accept_cycle", 64'(acc), 64'(exp_acc));
        first = (exp_acc + READ_LAT > last_end + 1) ? exp_acc + READ_LAT : last_end + 1;
        for (int k = 0; k < 4; k++)
            sb.push_back('{k: k, lo: first + k, hi: first + k + LAT_SPAN,
                           raddr: a & 32'hFFFF_FFE0, data: model[widx(a, k)]});
        last_end = first + LAT_SPAN + 3;
        pend_end.push_back(last_end);
    endtask

    initial begin
        int          line;
        logic [31:0] a;
        bif.bmem_addr  = '0;
        bif.bmem_read  = 1'b0;
        bif.bmem_write = 1'b0;
        bif.bmem_wdata = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_ready",  64'(bif.bmem_ready),  64'd0);
        check("rst_rvalid", 64'(bif.bmem_rvalid), 64'd0);
        check("rst_raddr",  64'(bif.bmem_raddr),  64'd0);
        check("rst_rdata",  bif.bmem_rdata,       64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_release", 64'(bif.bmem_ready), 64'd1);

        wd = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
               64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        do_write(32'h0000_0040, 4, 1'b0);
        do_read(32'h0000_0040);
        wait_idle();

        for (int l = 0; l < 4; l++) begin
            if (l != 2) begin
                for (int k = 0; k < 4; k++) wd[k] = {$urandom, $urandom};
                do_write(32'(l * 32), 4, 1'b0);
            end
        end
        for (int l = 0; l < 4; l++) do_read(32'(l * 32));
        do_read(32'h0000_0040);
        wait_idle();

        // Write wins over a simultaneous read; any return here is unexpected.
        for (int k = 0; k < 4; k++) wd[k] = {$urandom, $urandom};
        do_write(32'h0000_0080, 4, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        do_read(32'h0000_0080);
        wait_idle();

        wd = '{64'hA0A0_A0A0_A0A0_A0A0, 64'hA1A1_A1A1_A1A1_A1A1,
               64'hA2A2_A2A2_A2A2_A2A2, 64'hA3A3_A3A3_A3A3_A3A3};
        do_write(32'h0000_0040, 2, 1'b0);
        do_read(32'h0000_0040);
        wait_idle();

        do_read(32'h0000_0060);
        while (cyc < last_end - 1) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("rst_mid_rvalid", 64'(bif.bmem_rvalid), 64'd0);
        check("rst_mid_ready",  64'(bif.bmem_ready),  64'd0);
        sb.delete();
        pend_end.delete();
        last_end = -1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_mid_reset", 64'(bif.bmem_ready), 64'd1);
        do_read(32'h0000_0040);
        do_read(32'h0000_0020);
        wait_idle();

        for (int it = 0; it < 40; it++) begin
            line = $urandom_range(0, 4);
            a    = (32'(line) << 5) | ($urandom & 32'hFFFF_801F);
            if ($urandom_range(0, 3) == 0) begin
                wait_idle();
                for (int k = 0; k < 4; k++) wd[k] = {$urandom, $urandom};
                do_write(a, 4, 1'b0);
            end else begin
                do_read(a);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
        end
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end
endmodule
